// File: rtl/uart_pkt_pkg.sv
// Shared types, default framing constants and baud helper for the UART packet receiver.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        S_HEAD,
        S_PAY,
        S_CHK,
        S_TAIL0,
        S_TAIL1
    } pkt_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_t;

    localparam logic [7:0] DEF_HEAD_BYTE = 8'h55;
    localparam logic [7:0] DEF_TAIL0     = 8'h0D;
    localparam logic [7:0] DEF_TAIL1     = 8'h0A;

    function automatic int unsigned baud_cnt(input int unsigned clk, input int unsigned bps);
        return clk / bps;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte deserialiser: 2-flop synchroniser, start re-check at half bit,
// mid-bit sampling, and a return to idle right after the stop-bit sample.
module uart_byte_rx
    import uart_pkt_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 230_400
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       err_frame
);

    localparam int unsigned BAUD_CNT = baud_cnt(CLK_FREQ, UART_BPS);
    localparam int unsigned CNT_W    = $clog2(BAUD_CNT + 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_CNT / 2 - 1);

    logic [1:0]       rx_sync;
    logic             rx_prev;
    logic             rx;
    byte_state_t      state;
    byte_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             start_edge;
    logic             half_hit;
    logic             full_hit;
    logic             cnt_clr;
    logic             shift_en;
    logic             byte_ok;
    logic             byte_bad;

    assign rx         = rx_sync[1];
    assign start_edge = rx_prev & ~rx;
    assign half_hit   = (cnt == HALF_LAST);
    assign full_hit   = (cnt == FULL_LAST);

    // Synchronise the asynchronous pin; reset to idle-high so no false edge follows reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_sync <= '1;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rxd};
            rx_prev <= rx;
        end
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= B_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a high line at the half-bit point is a false start.
    always_comb begin
        state_nxt = state;
        case (state)
            B_IDLE:  if (start_edge) state_nxt = B_START;
            B_START: if (half_hit) state_nxt = rx ? B_IDLE : B_DATA;
            B_DATA:  if (full_hit && bit_idx == 3'd7) state_nxt = B_STOP;
            B_STOP:  if (full_hit) state_nxt = B_IDLE;
            default: state_nxt = B_IDLE;
        endcase
    end

    // Output decode: counter control, bit shift strobe and stop-bit verdict.
    always_comb begin
        cnt_clr  = (state == B_IDLE) || (state_nxt != state) || full_hit;
        shift_en = (state == B_DATA) && full_hit;
        byte_ok  = (state == B_STOP) && full_hit && rx;
        byte_bad = (state == B_STOP) && full_hit && !rx;
    end

    // Bit-time counter, LSB-first shift register and registered byte outputs.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + 1'b1;
            if (state != B_DATA) begin
                bit_idx <= '0;
            end else if (full_hit) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shreg <= {rx, shreg[7:1]};
            end
            byte_valid <= byte_ok;
            err_frame  <= byte_bad;
            if (byte_ok) begin
                byte_data <= shreg;
            end
        end
    end

endmodule

// File: rtl/uart_pkt_rx.sv
// Packet receiver: header, PAYLOAD_LEN payload bytes, optional XOR checksum,
// two tail bytes; delivers the payload as one flat vector with a valid pulse.
module uart_pkt_rx
    import uart_pkt_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned UART_BPS     = 230_400,
    parameter int unsigned PAYLOAD_LEN  = 5,
    parameter logic [7:0]  HEAD_BYTE    = DEF_HEAD_BYTE,
    parameter logic [7:0]  TAIL0        = DEF_TAIL0,
    parameter logic [7:0]  TAIL1        = DEF_TAIL1,
    parameter bit          CHK_EN       = 1'b0,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     uart_rxd,
    output logic [7:0]               byte_data,
    output logic                     byte_valid,
    output logic [8*PAYLOAD_LEN-1:0] pkt_data,
    output logic                     pkt_valid,
    output logic                     pkt_busy,
    output logic [7:0]               pkt_count,
    output logic                     err_frame,
    output logic                     err_tail,
    output logic                     err_chk,
    output logic                     err_timeout
);

    localparam int unsigned BAUD_CNT = baud_cnt(CLK_FREQ, UART_BPS);
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * BAUD_CNT;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
    localparam int unsigned IDX_W    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_LEN - 1);
    localparam logic [TO_W-1:0]  TO_HIT   = TO_W'(TO_LIMIT);

    logic [7:0]               rx_byte;
    logic                     rx_valid;
    logic                     rx_ferr;
    pkt_state_t               state;
    pkt_state_t               state_nxt;
    logic [IDX_W-1:0]         idx;
    logic [7:0]               xor_acc;
    logic [8*PAYLOAD_LEN-1:0] shadow;
    logic [TO_W-1:0]          to_cnt;
    logic                     to_hit;
    logic                     head_ok;
    logic                     pay_wr;
    logic                     pkt_done;
    logic                     chk_fail;
    logic                     tail_fail;
    logic                     to_fire;

    uart_byte_rx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_byte_rx (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .uart_rxd   (uart_rxd),
        .byte_data  (rx_byte),
        .byte_valid (rx_valid),
        .err_frame  (rx_ferr)
    );

    assign byte_data = rx_byte;
    assign byte_valid = rx_valid;
    assign err_frame  = rx_ferr;
    assign pkt_busy   = (state != S_HEAD);
    assign to_hit     = (state != S_HEAD) && (to_cnt == TO_HIT);

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= S_HEAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a received byte takes priority over a coincident timeout.
    always_comb begin
        state_nxt = state;
        if (rx_valid) begin
            case (state)
                S_HEAD:  if (rx_byte == HEAD_BYTE) state_nxt = S_PAY;
                S_PAY:   if (idx == IDX_LAST) state_nxt = CHK_EN ? S_CHK : S_TAIL0;
                S_CHK:   state_nxt = (rx_byte == xor_acc) ? S_TAIL0 : S_HEAD;
                S_TAIL0: state_nxt = (rx_byte == TAIL0) ? S_TAIL1 : S_HEAD;
                S_TAIL1: state_nxt = S_HEAD;
                default: state_nxt = S_HEAD;
            endcase
        end else if (rx_ferr || to_hit) begin
            state_nxt = S_HEAD;
        end
    end

    // Output decode: per-byte actions and the verdicts registered as pulses.
    always_comb begin
        head_ok   = rx_valid && (state == S_HEAD) && (rx_byte == HEAD_BYTE);
        pay_wr    = rx_valid && (state == S_PAY);
        pkt_done  = rx_valid && (state == S_TAIL1) && (rx_byte == TAIL1);
        chk_fail  = rx_valid && (state == S_CHK) && (rx_byte != xor_acc);
        tail_fail = rx_valid && (((state == S_TAIL0) && (rx_byte != TAIL0)) ||
                                 ((state == S_TAIL1) && (rx_byte != TAIL1)));
        to_fire   = to_hit && !rx_valid;
    end

    // Payload shadow, running XOR, index and inter-byte gap counter.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            idx     <= '0;
            xor_acc <= '0;
            shadow  <= '0;
            to_cnt  <= '0;
        end else begin
            if (head_ok) begin
                idx     <= '0;
                xor_acc <= '0;
            end else if (pay_wr) begin
                idx                      <= idx + 1'b1;
                xor_acc                  <= xor_acc ^ rx_byte;
                shadow[int'(idx)*8 +: 8] <= rx_byte;
            end
            if ((state == S_HEAD) || rx_valid) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_HIT) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Packet delivery, good-packet counter and error pulses.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pkt_data    <= '0;
            pkt_valid   <= 1'b0;
            pkt_count   <= '0;
            err_tail    <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            pkt_valid   <= pkt_done;
            err_tail    <= tail_fail;
            err_chk     <= chk_fail;
            err_timeout <= to_fire;
            if (pkt_done) begin
                pkt_data  <= shadow;
                pkt_count <= pkt_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Self-checking bench for uart_pkt_rx: directed scenarios plus randomized
// streams checked against a positional frame-scanning reference model.
module tb_uart_pkt_rx;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned UART_BPS = 3_125_000;
    localparam int unsigned BAUD     = CLK_FREQ / UART_BPS;
    localparam int unsigned PL       = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd0 = 1'b1;
    logic rxd1 = 1'b1;

    logic [7:0]      bd0, bd1, pc0, pc1;
    logic [8*PL-1:0] pd0, pd1;
    logic bv0, bv1, pv0, pv1, busy0, busy1;
    logic ef0, ef1, et0, et1, ec0, ec1, eto0, eto1;

    int tot = 0;
    int bad = 0;

    logic [39:0] got0[$];
    logic [39:0] got1[$];
    int n_byte[2]  = '{0, 0};
    int n_tail[2]  = '{0, 0};
    int n_chk[2]   = '{0, 0};
    int n_to[2]    = '{0, 0};
    int n_frame[2] = '{0, 0};

    logic [39:0] exp_pkts[$];
    int exp_tail;
    int exp_chk;
    logic [7:0] exp_cnt0;
    logic [7:0] exp_cnt1;

    always #10 clk = ~clk;

    uart_pkt_rx #(
        .CLK_FREQ (CLK_FREQ), .UART_BPS (UART_BPS), .PAYLOAD_LEN (PL),
        .HEAD_BYTE (8'h55), .TAIL0 (8'h0D), .TAIL1 (8'h0A),
        .CHK_EN (1'b0), .TIMEOUT_BITS (20)
    ) dut (
        .sys_clk (clk), .sys_rst_n (rst_n), .uart_rxd (rxd0),
        .byte_data (bd0), .byte_valid (bv0), .pkt_data (pd0), .pkt_valid (pv0),
        .pkt_busy (busy0), .pkt_count (pc0), .err_frame (ef0), .err_tail (et0),
        .err_chk (ec0), .err_timeout (eto0)
    );

    uart_pkt_rx #(
        .CLK_FREQ (CLK_FREQ), .UART_BPS (UART_BPS), .PAYLOAD_LEN (PL),
        .HEAD_BYTE (8'h55), .TAIL0 (8'h0D), .TAIL1 (8'h0A),
        .CHK_EN (1'b1), .TIMEOUT_BITS (20)
    ) dut_chk (
        .sys_clk (clk), .sys_rst_n (rst_n), .uart_rxd (rxd1),
        .byte_data (bd1), .byte_valid (bv1), .pkt_data (pd1), .pkt_valid (pv1),
        .pkt_busy (busy1), .pkt_count (pc1), .err_frame (ef1), .err_tail (et1),
        .err_chk (ec1), .err_timeout (eto1)
    );

    // Pulse monitor: every cycle a pulse is high counts once.
    always @(negedge clk) begin
        if (pv0) got0.push_back(pd0);
        if (pv1) got1.push_back(pd1);
        if (bv0) n_byte[0]++;
        if (bv1) n_byte[1]++;
        if (et0) n_tail[0]++;
        if (et1) n_tail[1]++;
        if (ec0) n_chk[0]++;
        if (ec1) n_chk[1]++;
        if (eto0) n_to[0]++;
        if (eto1) n_to[1]++;
        if (ef0) n_frame[0]++;
        if (ef1) n_frame[1]++;
    end

    function automatic int err_sum(input int w);
        return n_tail[w] + n_chk[w] + n_to[w] + n_frame[w];
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input int w, input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (w == 0) rxd0 = fr[i]; else rxd1 = fr[i];
            wait_cycles(BAUD);
        end
        if (w == 0) rxd0 = 1'b1; else rxd1 = 1'b1;
    endtask

    // Sends the n bytes of v, most significant byte first.
    task automatic send_bytes(input int w, input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) send_byte(w, v[8*(n-1-i) +: 8], 1'b1);
    endtask

    task automatic settle();
        wait_cycles(2 * BAUD);
    endtask

    // Scans the stream for frames by position: header, payload, optional
    // checksum, tails; an offending byte ends the frame and is not rescanned.
    task automatic model_run(input logic [7:0] s[$], input bit chk);
        int p;
        int q;
        int n;
        logic [39:0] pay;
        logic [7:0] x;
        p = 0;
        n = s.size();
        exp_pkts.delete();
        exp_tail = 0;
        exp_chk = 0;
        while (p < n) begin
            if (s[p] != 8'h55 || p + PL + (chk ? 1 : 0) + 2 >= n) begin
                p++;
            end else begin
                pay = '0;
                x = '0;
                for (int k = 0; k < PL; k++) begin
                    pay[8*k +: 8] = s[p+1+k];
                    x ^= s[p+1+k];
                end
                q = p + 1 + PL;
                if (chk && s[q] != x) begin
                    exp_chk++;
                    p = q + 1;
                end else begin
                    if (chk) q++;
                    if (s[q] != 8'h0D) begin
                        exp_tail++;
                        p = q + 1;
                    end else if (s[q+1] != 8'h0A) begin
                        exp_tail++;
                        p = q + 2;
                    end else begin
                        exp_pkts.push_back(pay);
                        p = q + 2;
                    end
                end
            end
        end
    endtask

    function automatic logic [7:0] bad_byte(input logic [7:0] avoid);
        logic [7:0] b;
        b = 8'(($urandom_range(0, 255)));
        while (b == avoid || b == 8'h55) b = b + 8'd1;
        return b;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(3);
        tot++;
        if ({bd0, bv0, pd0, pv0, busy0, pc0, ef0, et0, ec0, eto0} !== '0) begin
            bad++;
            $display("FAIL reset_dut: got=%h want=0", {bd0, bv0, pd0, pv0, busy0, pc0, ef0, et0, ec0, eto0});
        end
        tot++;
        if ({bd1, bv1, pd1, pv1, busy1, pc1, ef1, et1, ec1, eto1} !== '0) begin
            bad++;
            $display("FAIL reset_dut_chk: got=%h want=0", {bd1, bv1, pd1, pv1, busy1, pc1, ef1, et1, ec1, eto1});
        end
        rst_n = 1'b1;
        wait_cycles(4);
        tot++;
        if ({pv0, busy0, pc0, pd0} !== '0) begin
            bad++;
            $display("FAIL reset_release: got=%h want=0", {pv0, busy0, pc0, pd0});
        end
    endtask

    task automatic test_single();
        int g = got0.size();
        int nb = n_byte[0];
        int ne = err_sum(0);
        send_bytes(0, 128'h55_12_13_14_15_16_0D_0A, 8);
        settle();
        tot++;
        if (got0.size() - g != 1) begin bad++; $display("FAIL single_npkt: got=%0d want=1", got0.size() - g); end
        tot++;
        if (pd0 !== 40'h16_15_14_13_12) begin bad++; $display("FAIL single_data: got=%h want=1615141312", pd0); end
        tot++;
        if (pc0 !== 8'd1) begin bad++; $display("FAIL single_count: got=%0d want=1", pc0); end
        tot++;
        if (err_sum(0) - ne != 0) begin bad++; $display("FAIL single_err: got=%0d want=0", err_sum(0) - ne); end
        tot++;
        if (n_byte[0] - nb != 8) begin bad++; $display("FAIL single_bytes: got=%0d want=8", n_byte[0] - nb); end
        tot++;
        if (bd0 !== 8'h0A || busy0 !== 1'b0) begin bad++; $display("FAIL single_last: got=%h/%b want=0a/0", bd0, busy0); end
    endtask

    task automatic test_back_to_back();
        int g = got0.size();
        int ne = err_sum(0);
        send_bytes(0, 128'h55_12_13_14_15_16_0D_0A_55_32_33_34_35_36_0D_0A, 16);
        settle();
        tot++;
        if (got0.size() - g != 2) begin
            bad++;
            $display("FAIL b2b_npkt: got=%0d want=2", got0.size() - g);
        end else begin
            tot++;
            if (got0[g] !== 40'h16_15_14_13_12) begin bad++; $display("FAIL b2b_first: got=%h want=1615141312", got0[g]); end
            tot++;
            if (got0[g+1] !== 40'h36_35_34_33_32) begin bad++; $display("FAIL b2b_second: got=%h want=3635343332", got0[g+1]); end
        end
        tot++;
        if (pc0 !== 8'd3) begin bad++; $display("FAIL b2b_count: got=%0d want=3", pc0); end
        tot++;
        if (err_sum(0) - ne != 0) begin bad++; $display("FAIL b2b_err: got=%0d want=0", err_sum(0) - ne); end
    endtask

    task automatic test_junk_and_tail();
        int g = got0.size();
        int nt = n_tail[0];
        send_bytes(0, 128'hAA_00_55_12_13_14_15_16_0D_0A, 10);
        settle();
        tot++;
        if (got0.size() - g != 1) begin bad++; $display("FAIL junk_npkt: got=%0d want=1", got0.size() - g); end
        tot++;
        if (pc0 !== 8'd4) begin bad++; $display("FAIL junk_count: got=%0d want=4", pc0); end
        g = got0.size();
        send_bytes(0, 128'h55_21_22_23_24_25_0D_0B, 8);
        settle();
        tot++;
        if (n_tail[0] - nt != 1) begin bad++; $display("FAIL tail_err: got=%0d want=1", n_tail[0] - nt); end
        tot++;
        if (pd0 !== 40'h16_15_14_13_12) begin bad++; $display("FAIL tail_data_kept: got=%h want=1615141312", pd0); end
        tot++;
        if (got0.size() != g || pc0 !== 8'd4) begin bad++; $display("FAIL tail_nopkt: got=%0d/%0d want=0/4", got0.size() - g, pc0); end
    endtask

    task automatic test_checksum();
        int g = got1.size();
        int nc = n_chk[1];
        int ne = err_sum(1);
        send_bytes(1, 128'h55_01_02_03_04_05_01_0D_0A, 9);
        settle();
        tot++;
        if (got1.size() - g != 1) begin bad++; $display("FAIL chk_good_npkt: got=%0d want=1", got1.size() - g); end
        tot++;
        if (pd1 !== 40'h05_04_03_02_01 || pc1 !== 8'd1) begin bad++; $display("FAIL chk_good_data: got=%h/%0d want=0504030201/1", pd1, pc1); end
        tot++;
        if (err_sum(1) - ne != 0) begin bad++; $display("FAIL chk_good_err: got=%0d want=0", err_sum(1) - ne); end
        g = got1.size();
        send_bytes(1, 128'h55_01_02_03_04_05_00_0D_0A, 9);
        settle();
        tot++;
        if (n_chk[1] - nc != 1) begin bad++; $display("FAIL chk_bad_err: got=%0d want=1", n_chk[1] - nc); end
        tot++;
        if (got1.size() != g || busy1 !== 1'b0) begin bad++; $display("FAIL chk_bad_nopkt: got=%0d/%b want=0/0", got1.size() - g, busy1); end
    endtask

    task automatic test_timeout();
        int nt = n_to[0];
        int g = got0.size();
        send_bytes(0, 128'h55_12_13, 3);
        tot++;
        if (busy0 !== 1'b1) begin bad++; $display("FAIL to_busy: got=%b want=1", busy0); end
        wait_cycles(18 * BAUD);
        tot++;
        if (n_to[0] - nt != 0) begin bad++; $display("FAIL to_early: got=%0d want=0", n_to[0] - nt); end
        wait_cycles(7 * BAUD);
        tot++;
        if (n_to[0] - nt != 1) begin bad++; $display("FAIL to_fire: got=%0d want=1", n_to[0] - nt); end
        tot++;
        if (busy0 !== 1'b0 || got0.size() != g) begin bad++; $display("FAIL to_idle: got=%b/%0d want=0/0", busy0, got0.size() - g); end
    endtask

    task automatic test_frame();
        int nf = n_frame[0];
        int nb = n_byte[0];
        send_byte(0, 8'hA5, 1'b0);
        settle();
        tot++;
        if (n_frame[0] - nf != 1 || n_byte[0] - nb != 0) begin
            bad++;
            $display("FAIL frame_idle: got=%0d/%0d want=1/0", n_frame[0] - nf, n_byte[0] - nb);
        end
        send_bytes(0, 128'h55_12, 2);
        send_byte(0, 8'h13, 1'b0);
        settle();
        tot++;
        if (busy0 !== 1'b0 || n_frame[0] - nf != 2 || n_byte[0] - nb != 2) begin
            bad++;
            $display("FAIL frame_abort: got=%b/%0d/%0d want=0/2/2", busy0, n_frame[0] - nf, n_byte[0] - nb);
        end
    endtask

    task automatic test_reset_mid();
        int ne;
        send_bytes(0, 128'h55_12, 2);
        wait_cycles(4);
        tot++;
        if (busy0 !== 1'b1) begin bad++; $display("FAIL rmid_busy: got=%b want=1", busy0); end
        rst_n = 1'b0;
        wait_cycles(2);
        tot++;
        if ({bd0, bv0, pd0, pv0, busy0, pc0, ef0, et0, ec0, eto0} !== '0) begin
            bad++;
            $display("FAIL rmid_zero: got=%h want=0", {bd0, bv0, pd0, pv0, busy0, pc0, ef0, et0, ec0, eto0});
        end
        rst_n = 1'b1;
        wait_cycles(2);
        ne = err_sum(0);
        send_bytes(0, 128'h55_41_42_43_44_45_0D_0A, 8);
        settle();
        tot++;
        if (pc0 !== 8'd1 || pd0 !== 40'h45_44_43_42_41) begin bad++; $display("FAIL rmid_after: got=%0d/%h want=1/4544434241", pc0, pd0); end
        tot++;
        if (err_sum(0) - ne != 0) begin bad++; $display("FAIL rmid_err: got=%0d want=0", err_sum(0) - ne); end
        exp_cnt0 = 8'd1;
        exp_cnt1 = 8'd0;
    endtask

    task automatic test_random(input int w, input int items);
        logic [7:0] s[$];
        logic [7:0] b;
        logic [7:0] x;
        int kind;
        int g = (w == 0) ? got0.size() : got1.size();
        int ng;
        int nb = n_byte[w];
        int nt = n_tail[w];
        int nc = n_chk[w];
        int nto = n_to[w] + n_frame[w];
        logic [39:0] gv;
        logic [7:0] pcv;
        logic [7:0] want_cnt;
        for (int it = 0; it < items; it++) begin
            kind = int'($urandom_range(0, 4));
            if (kind == 0) begin
                s.push_back(bad_byte(8'h55));
            end else begin
                s.push_back(8'h55);
                x = '0;
                for (int k = 0; k < PL; k++) begin
                    b = 8'($urandom_range(0, 255));
                    s.push_back(b);
                    x ^= b;
                end
                if (w == 1) s.push_back((kind == 1) ? (x ^ 8'(($urandom_range(1, 255)))) : x);
                s.push_back((kind == 2) ? bad_byte(8'h0D) : 8'h0D);
                s.push_back((kind == 3) ? bad_byte(8'h0A) : 8'h0A);
            end
        end
        foreach (s[i]) send_byte(w, s[i], 1'b1);
        settle();
        model_run(s, w == 1);
        ng = ((w == 0) ? got0.size() : got1.size()) - g;
        tot++;
        if (ng != exp_pkts.size()) begin
            bad++;
            $display("FAIL rand%0d_npkt: got=%0d want=%0d", w, ng, exp_pkts.size());
        end else begin
            for (int i = 0; i < ng; i++) begin
                gv = (w == 0) ? got0[g+i] : got1[g+i];
                tot++;
                if (gv !== exp_pkts[i]) begin bad++; $display("FAIL rand%0d_pkt%0d: got=%h want=%h", w, i, gv, exp_pkts[i]); end
            end
        end
        tot++;
        if (n_tail[w] - nt != exp_tail || n_chk[w] - nc != exp_chk) begin
            bad++;
            $display("FAIL rand%0d_errs: got=%0d/%0d want=%0d/%0d", w, n_tail[w] - nt, n_chk[w] - nc, exp_tail, exp_chk);
        end
        tot++;
        if (n_byte[w] - nb != s.size() || n_to[w] + n_frame[w] - nto != 0) begin
            bad++;
            $display("FAIL rand%0d_bytes: got=%0d/%0d want=%0d/0", w, n_byte[w] - nb, n_to[w] + n_frame[w] - nto, s.size());
        end
        pcv = (w == 0) ? pc0 : pc1;
        want_cnt = ((w == 0) ? exp_cnt0 : exp_cnt1) + 8'(exp_pkts.size());
        tot++;
        if (pcv !== want_cnt) begin bad++; $display("FAIL rand%0d_count: got=%0d want=%0d", w, pcv, want_cnt); end
        if (w == 0) exp_cnt0 = want_cnt; else exp_cnt1 = want_cnt;
    endtask

    initial begin
        exp_cnt0 = '0;
        exp_cnt1 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_junk_and_tail();
        test_checksum();
        test_timeout();
        test_frame();
        test_reset_mid();
        test_random(0, 6);
        test_random(0, 6);
        test_random(1, 5);
        test_random(1, 5);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
